mux_2_1: RTL and testbench

//   Two-input multiplexer: out = d0 when selector=0, out = d1 when selector=1.

---
 rtl/mux2_1_pkg.sv | 10 +
 rtl/mux2_1_edge_det.sv | 21 ++
 rtl/mux_2_1.sv | 63 ++++++
 tb/tb_mux_2_1.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux2_1_pkg.sv
// Shared constants for the 2:1 selector leaf: selector encodings and default widths.
package mux2_1_pkg;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mux2_1_edge_det.sv
// Registered change detector: chg pulses for one cycle whenever sig differs from its
// previous-cycle value. sig_q resets to 0, so a high sig right after reset counts as a change.
module mux2_1_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_q,
    output logic chg
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
            chg   <= 1'b0;
        end else begin
            sig_q <= sig;
            chg   <= sig ^ sig_q;
        end
    end

endmodule

// File: rtl/mux_2_1.sv
// Two-input multiplexer with a registered copy of the output and a selector-change strobe.
// Define MUX2_1_SEL_CNT_EN to build the saturating selector-toggle counter on sel_count.
module mux_2_1
    import mux2_1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selector,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] sel_count
);

    logic sel_q;

    // An unknown selector must show up as an unknown output rather than a merged value.
    always_comb begin
        case (selector)
            SEL_D0:  out = d0;
            SEL_D1:  out = d1;
            default: out = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out;
    end

    mux2_1_edge_det u_edge_det (
        .clk   (clk),
        .rst   (rst),
        .sig   (selector),
        .sig_q (sel_q),
        .chg   (sel_chg)
    );

`ifdef MUX2_1_SEL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sel_chg && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sel_count = cnt_q;
`else
    assign sel_count = '0;
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// Bench for mux_2_1: one WIDTH=1/CNT_W=2 instance and one WIDTH=8/CNT_W=8 instance
// checked against a cycle-level reference model under directed and random stimulus.
module tb_mux_2_1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       selector = 1'b0;
    logic       d0_1 = 1'b0, d1_1 = 1'b0;
    logic [7:0] d0_8 = '0, d1_8 = '0;

    logic       out_1, out_q_1, sel_chg_1;
    logic [1:0] sel_count_1;
    logic [7:0] out_8, out_q_8;
    logic       sel_chg_8;
    logic [7:0] sel_count_8;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic       m_prev_sel;
    logic       m_chg;
    logic       m_oq1;
    logic [7:0] m_oq8;
    int         m_cnt1, m_cnt8;

    mux_2_1 #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .selector  (selector),
        .d0        (d0_1),
        .d1        (d1_1),
        .out       (out_1),
        .out_q     (out_q_1),
        .sel_chg   (sel_chg_1),
        .sel_count (sel_count_1)
    );

    mux_2_1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .selector  (selector),
        .d0        (d0_8),
        .d1        (d1_8),
        .out       (out_8),
        .out_q     (out_q_8),
        .sel_chg   (sel_chg_8),
        .sel_count (sel_count_8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef MUX2_1_SEL_CNT_EN
        return c;
`else
        return 0 + (c & 0);
`endif
    endfunction

    task automatic model_reset();
        m_prev_sel = 1'b0;
        m_chg      = 1'b0;
        m_oq1      = 1'b0;
        m_oq8      = '0;
        m_cnt1     = 0;
        m_cnt8     = 0;
    endtask

    task automatic chk_side(input string tag);
        chk({tag, "_outq1"}, 32'(out_q_1), 32'(m_oq1));
        chk({tag, "_outq8"}, 32'(out_q_8), 32'(m_oq8));
        chk({tag, "_chg1"},  32'(sel_chg_1), 32'(m_chg));
        chk({tag, "_chg8"},  32'(sel_chg_8), 32'(m_chg));
        chk({tag, "_cnt1"},  32'(sel_count_1), 32'(exp_cnt(m_cnt1)));
        chk({tag, "_cnt8"},  32'(sel_count_8), 32'(exp_cnt(m_cnt8)));
    endtask

    // Called just after a falling edge: apply inputs, check the mux, step one clock.
    task automatic cycle(input string tag, input logic s, input logic a1, input logic b1,
                         input logic [7:0] a8, input logic [7:0] b8);
        selector = s;
        d0_1 = a1; d1_1 = b1; d0_8 = a8; d1_8 = b8;
        #1;
        chk({tag, "_out1"}, 32'(out_1), 32'(s ? b1 : a1));
        chk({tag, "_out8"}, 32'(out_8), 32'(s ? b8 : a8));
        @(posedge clk);
        if (m_chg) begin
            m_cnt1 = (m_cnt1 + 1 > 3)   ? 3   : m_cnt1 + 1;
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        end
        m_chg      = (s != m_prev_sel);
        m_prev_sel = s;
        m_oq1      = s ? b1 : a1;
        m_oq8      = s ? b8 : a8;
        @(negedge clk);
        chk_side(tag);
    endtask

    initial begin
        logic [1:0] pat;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk_side("rst");

        // Combinational sweeps while reset is held: out must ignore rst.
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            selector = 1'b0; d0_1 = pat[1]; d1_1 = pat[0];
            #1 chk("sweep_s0", 32'(out_1), 32'(pat[1]));
            selector = 1'b1;
            #1 chk("sweep_s1", 32'(out_1), 32'(pat[0]));
        end
        d0_1 = 1'b1; d1_1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            selector = ~selector;
            #10 chk("toggle", 32'(out_1), 32'(selector ? 1'b0 : 1'b1));
        end
        d0_8 = 8'hA5; d1_8 = 8'h3C;
        selector = 1'b0;
        #1 chk("w8_s0", 32'(out_8), 32'h A5);
        selector = 1'b1;
        #1 chk("w8_s1", 32'(out_8), 32'h 3C);

        // Release reset away from the clock edge.
        @(negedge clk);
        rst = 1'b0;
        cycle("hold",  1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
        chk("hold_outq_one", 32'(out_q_1), 32'd1);
        cycle("chg",   1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
        chk("chg_pulse", 32'(sel_chg_1), 32'd1);
        cycle("after", 1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
        chk("chg_drop", 32'(sel_chg_1), 32'd0);

        // Mid-run reset between clock edges.
        cycle("pre", 1'b0, 1'b1, 1'b0, 8'hF0, 8'h0F);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_side("midrst");
        d0_1 = 1'b0;
        #1 chk("midrst_out", 32'(out_1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Five toggles, then hold: CNT_W=2 counter saturates at 3.
        for (int i = 0; i < 5; i++)
            cycle("tog5", (i % 2 == 0), 1'b0, 1'b1, 8'h01, 8'h02);
        for (int i = 0; i < 3; i++)
            cycle("tog5h", 1'b0, 1'b0, 1'b1, 8'h01, 8'h02);
        chk("sat_cnt1", 32'(sel_count_1), 32'(exp_cnt(3)));

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cycle("rnd", 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
